// File: rtl/sdram_aref_ctrl_if.sv
// +--------------------------------------------------------------------------+
// | sdram_aref_ctrl_if : arbiter <-> auto-refresh engine handshake and bus    |
// | Optional AREF_STATS_EN adds the statistics signals.  Rev 1.0              |
// +--------------------------------------------------------------------------+
`default_nettype none

interface sdram_aref_ctrl_if #(
  parameter int BA_W   = 2,
  parameter int ADDR_W = 13
);
  logic              aref_en;
  logic              aref_req;
  logic              aref_urgent;
  logic              aref_busy;
  logic [3:0]        aref_cmd_out;
  logic [BA_W-1:0]   aref_ba_out;
  logic [ADDR_W-1:0] aref_addr_out;
  logic              aref_end;
  logic [3:0]        aref_debt;
`ifdef AREF_STATS_EN
  logic [15:0]       aref_total;
  logic              aref_overflow;

  // Arbiter side
  modport master (
    output aref_en,
    input  aref_req, aref_urgent, aref_busy, aref_cmd_out, aref_ba_out,
    input  aref_addr_out, aref_end, aref_debt, aref_total, aref_overflow
  );

  // Refresh engine side
  modport slave (
    input  aref_en,
    output aref_req, aref_urgent, aref_busy, aref_cmd_out, aref_ba_out,
    output aref_addr_out, aref_end, aref_debt, aref_total, aref_overflow
  );
`else
  modport master (
    output aref_en,
    input  aref_req, aref_urgent, aref_busy, aref_cmd_out, aref_ba_out,
    input  aref_addr_out, aref_end, aref_debt
  );

  modport slave (
    input  aref_en,
    output aref_req, aref_urgent, aref_busy, aref_cmd_out, aref_ba_out,
    output aref_addr_out, aref_end, aref_debt
  );
`endif
endinterface

`default_nettype wire

// File: rtl/sdram_aref_ctrl.sv
// +--------------------------------------------------------------------------+
// | sdram_aref_ctrl : SDRAM auto-refresh engine with refresh-debt tracking    |
// | Optional AREF_STATS_EN adds AUTO REFRESH total and overflow flag. Rev 1.0 |
// +--------------------------------------------------------------------------+
`default_nettype none

module sdram_aref_ctrl #(
  parameter int REF_INTERVAL = 1550,
  parameter int TRP_CYC      = 2,
  parameter int TRFC_CYC     = 7,
  parameter int REFS_PER_REQ = 1,
  parameter int MAX_DEBT     = 8,
  parameter int BA_W         = 2,
  parameter int ADDR_W       = 13
) (
  input  wire logic        sys_clk,
  input  wire logic        sys_rst_n,
  input  wire logic        init_end,
  sdram_aref_ctrl_if.slave aref
);

  localparam int C_INT_W  = (REF_INTERVAL > 2) ? $clog2(REF_INTERVAL) : 1;
  localparam int C_WMAX   = (TRP_CYC > TRFC_CYC) ? TRP_CYC : TRFC_CYC;
  localparam int C_WAIT_W = $clog2(C_WMAX + 1);

  localparam logic [C_INT_W-1:0]  C_INT_LAST  = C_INT_W'(REF_INTERVAL - 1);
  localparam logic [C_WAIT_W-1:0] C_TRP_LAST  = C_WAIT_W'(TRP_CYC - 1);
  localparam logic [C_WAIT_W-1:0] C_TRFC_LAST = C_WAIT_W'(TRFC_CYC - 1);
  localparam logic [1:0]          C_LAST_IDX  = 2'(REFS_PER_REQ - 1);
  localparam logic [3:0]          C_MAX_DEBT  = 4'(MAX_DEBT);
  localparam logic [3:0]          C_URGENT    = 4'(MAX_DEBT - 1);
  localparam logic [BA_W-1:0]     C_BA_ALL    = '1;
  localparam logic [ADDR_W-1:0]   C_ADDR_ALL  = '1;

  localparam logic [3:0] C_CMD_NOP  = 4'b0111;
  localparam logic [3:0] C_CMD_PRE  = 4'b0010;
  localparam logic [3:0] C_CMD_AREF = 4'b0001;

  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_PRECH     = 3'd1;
  localparam logic [2:0] S_WAIT_TRP  = 3'd2;
  localparam logic [2:0] S_AREF      = 3'd3;
  localparam logic [2:0] S_WAIT_TRFC = 3'd4;
  localparam logic [2:0] S_END       = 3'd5;

  logic [2:0]          r_state;
  logic [2:0]          w_state_nxt;
  logic [C_INT_W-1:0]  r_int_cnt;
  logic                w_tick;
  logic [3:0]          r_debt;
  logic [3:0]          w_debt_nxt;
  logic [C_WAIT_W-1:0] r_wait_cnt;
  logic [1:0]          r_ref_idx;
  logic [3:0]          r_cmd;
  logic [3:0]          w_cmd_nxt;
  logic                w_end;
  logic                w_busy;
  logic                w_req;

  // Refresh interval timer; parked at zero until initialisation completes
  assign w_tick = init_end && (r_int_cnt == C_INT_LAST);

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_int_cnt <= '0;
    end else if (!init_end || w_tick) begin
      r_int_cnt <= '0;
    end else begin
      r_int_cnt <= r_int_cnt + 1'b1;
    end
  end

  // Debt: a tick and a finished service in the same cycle cancel out
  always_comb begin
    w_debt_nxt = r_debt;
    if (w_tick && !w_end) begin
      if (r_debt != C_MAX_DEBT) begin
        w_debt_nxt = r_debt + 4'd1;
      end
    end else if (w_end && !w_tick) begin
      w_debt_nxt = r_debt - 4'd1;
    end
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_debt <= 4'd0;
    end else begin
      r_debt <= w_debt_nxt;
    end
  end

  assign w_req = (r_debt != 4'd0);

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (aref.aref_en && w_req && init_end) begin
          w_state_nxt = S_PRECH;
        end
      end
      S_PRECH:    w_state_nxt = S_WAIT_TRP;
      S_WAIT_TRP: begin
        if (r_wait_cnt == C_TRP_LAST) begin
          w_state_nxt = S_AREF;
        end
      end
      S_AREF:     w_state_nxt = S_WAIT_TRFC;
      S_WAIT_TRFC: begin
        if (r_wait_cnt == C_TRFC_LAST) begin
          w_state_nxt = (r_ref_idx < C_LAST_IDX) ? S_AREF : S_END;
        end
      end
      S_END:      w_state_nxt = S_IDLE;
      default:    w_state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    w_cmd_nxt = C_CMD_NOP;
    w_end     = 1'b0;
    w_busy    = (r_state != S_IDLE);
    case (r_state)
      S_PRECH: w_cmd_nxt = C_CMD_PRE;
      S_AREF:  w_cmd_nxt = C_CMD_AREF;
      S_END:   w_end     = 1'b1;
      default: w_cmd_nxt = C_CMD_NOP;
    endcase
  end

  // Wait counter restarts from zero whenever a wait state is (re)entered
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_wait_cnt <= '0;
    end else if (r_state != w_state_nxt) begin
      r_wait_cnt <= '0;
    end else if (r_state == S_WAIT_TRP || r_state == S_WAIT_TRFC) begin
      r_wait_cnt <= r_wait_cnt + 1'b1;
    end else begin
      r_wait_cnt <= '0;
    end
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_ref_idx <= 2'd0;
    end else if (r_state == S_PRECH) begin
      r_ref_idx <= 2'd0;
    end else if (r_state == S_WAIT_TRFC && w_state_nxt == S_AREF) begin
      r_ref_idx <= r_ref_idx + 2'd1;
    end
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_cmd <= C_CMD_NOP;
    end else begin
      r_cmd <= w_cmd_nxt;
    end
  end

`ifdef AREF_STATS_EN
  logic [15:0] r_total;
  logic        r_overflow;

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_total    <= 16'd0;
      r_overflow <= 1'b0;
    end else begin
      if (r_state == S_AREF) begin
        r_total <= r_total + 16'd1;
      end
      if (w_tick && (r_debt == C_MAX_DEBT)) begin
        r_overflow <= 1'b1;
      end
    end
  end

  assign aref.aref_total    = r_total;
  assign aref.aref_overflow = r_overflow;
`endif

  assign aref.aref_req      = w_req;
  assign aref.aref_urgent   = (r_debt >= C_URGENT);
  assign aref.aref_busy     = w_busy;
  assign aref.aref_end      = w_end;
  assign aref.aref_debt     = r_debt;
  assign aref.aref_cmd_out  = r_cmd;
  assign aref.aref_ba_out   = C_BA_ALL;
  assign aref.aref_addr_out = C_ADDR_ALL;

endmodule

`default_nettype wire

// File: tb/tb_sdram_aref_ctrl.sv
// +--------------------------------------------------------------------------+
// | tb_sdram_aref_ctrl : directed bench for the SDRAM auto-refresh engine     |
// | Rev 1.0                                                                   |
// +--------------------------------------------------------------------------+
`default_nettype none

module tb_sdram_aref_ctrl;

  localparam logic [3:0] NOP  = 4'b0111;
  localparam logic [3:0] PRE  = 4'b0010;
  localparam logic [3:0] AREF = 4'b0001;

  logic sys_clk;
  logic sys_rst_n;
  logic init_end;
  logic init_end2;

  int vectors     = 0;
  int miscompares = 0;
  int ecnt        = 0;
  int ends        = 0;
  logic [3:0] exp_cmd;

  sdram_aref_ctrl_if #(.BA_W(2), .ADDR_W(13)) bus  ();
  sdram_aref_ctrl_if #(.BA_W(2), .ADDR_W(13)) bus2 ();

  sdram_aref_ctrl dut (
    .sys_clk   (sys_clk),
    .sys_rst_n (sys_rst_n),
    .init_end  (init_end),
    .aref      (bus.slave)
  );

  sdram_aref_ctrl #(.REF_INTERVAL(20), .REFS_PER_REQ(2)) dut2 (
    .sys_clk   (sys_clk),
    .sys_rst_n (sys_rst_n),
    .init_end  (init_end2),
    .aref      (bus2.slave)
  );

  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Advance to 1 time unit after the given post-start clock edge
  task automatic step_to(input int target);
    while (ecnt < target) begin
      @(posedge sys_clk);
      #1;
      ecnt++;
    end
  endtask

  initial begin
    sys_rst_n    = 1'b0;
    init_end     = 1'b0;
    init_end2    = 1'b0;
    bus.aref_en  = 1'b0;
    bus2.aref_en = 1'b0;
    repeat (2) @(posedge sys_clk);
    #1;

    check("rst_cmd",    32'(bus.aref_cmd_out),  32'(NOP));
    check("rst_ba",     32'(bus.aref_ba_out),   32'h3);
    check("rst_addr",   32'(bus.aref_addr_out), 32'h1FFF);
    check("rst_debt",   32'(bus.aref_debt),     32'd0);
    check("rst_req",    32'(bus.aref_req),      32'd0);
    check("rst_urgent", 32'(bus.aref_urgent),   32'd0);
    check("rst_busy",   32'(bus.aref_busy),     32'd0);
    check("rst_end",    32'(bus.aref_end),      32'd0);

    // Single service after the first tick
    sys_rst_n   = 1'b1;
    init_end    = 1'b1;
    bus.aref_en = 1'b1;
    ecnt        = 0;
    step_to(1549);
    check("t1_req_early", 32'(bus.aref_req), 32'd0);
    step_to(1550);
    check("t1_req",  32'(bus.aref_req),  32'd1);
    check("t1_debt", 32'(bus.aref_debt), 32'd1);
    check("t1_idle", 32'(bus.aref_busy), 32'd0);
    for (int e = 1551; e <= 1563; e++) begin
      step_to(e);
      exp_cmd = (e == 1552) ? PRE : (e == 1555) ? AREF : NOP;
      check("t1_cmd",  32'(bus.aref_cmd_out), 32'(exp_cmd));
      check("t1_end",  32'(bus.aref_end),     32'(e == 1562));
      check("t1_busy", 32'(bus.aref_busy),    32'(e <= 1562));
    end
    check("t1_debt_after", 32'(bus.aref_debt), 32'd0);
    check("t1_req_after",  32'(bus.aref_req),  32'd0);
    bus.aref_en = 1'b0;

    // Service ending exactly on a tick with debt 3
    step_to(7737);
    check("t4_debt_pre", 32'(bus.aref_debt), 32'd3);
    bus.aref_en = 1'b1;
    step_to(7738);
    check("t4_busy", 32'(bus.aref_busy), 32'd1);
    bus.aref_en = 1'b0;
    step_to(7749);
    check("t4_end",      32'(bus.aref_end),  32'd1);
    check("t4_debt_end", 32'(bus.aref_debt), 32'd3);
    step_to(7750);
    check("t4_debt_tick", 32'(bus.aref_debt), 32'd3);
    check("t4_idle",      32'(bus.aref_busy), 32'd0);

    // Debt accumulation, urgency and saturation
    step_to(12400);
    check("t3_debt6",   32'(bus.aref_debt),   32'd6);
    check("t3_urg6",    32'(bus.aref_urgent), 32'd0);
    step_to(13950);
    check("t3_debt7",   32'(bus.aref_debt),   32'd7);
    check("t3_urg7",    32'(bus.aref_urgent), 32'd1);
    step_to(15500);
    check("t3_debt8",   32'(bus.aref_debt),   32'd8);
`ifdef AREF_STATS_EN
    check("t3_ovf0",    32'(bus.aref_overflow), 32'd0);
`endif
    step_to(17050);
    check("t3_debt_sat", 32'(bus.aref_debt),  32'd8);
    check("t3_urg_sat",  32'(bus.aref_urgent), 32'd1);
`ifdef AREF_STATS_EN
    check("t3_ovf1",    32'(bus.aref_overflow), 32'd1);
`endif
    bus.aref_en = 1'b1;
    for (int e = 17051; e <= 17154; e++) begin
      step_to(e);
      if (bus.aref_end === 1'b1) ends++;
      if (e == 17063) check("t3_gap_idle", 32'(bus.aref_busy), 32'd0);
      if (e == 17064) check("t3_gap_busy", 32'(bus.aref_busy), 32'd1);
    end
    check("t3_ends",      32'(ends),           32'd8);
    check("t3_debt_zero", 32'(bus.aref_debt),  32'd0);
    check("t3_idle",      32'(bus.aref_busy),  32'd0);
`ifdef AREF_STATS_EN
    check("t3_total",     32'(bus.aref_total), 32'd10);
`endif

    // Reset while waiting tRFC
    step_to(18600);
    check("t5_debt", 32'(bus.aref_debt), 32'd1);
    step_to(18605);
    check("t5_cmd_aref", 32'(bus.aref_cmd_out), 32'(AREF));
    check("t5_busy_pre", 32'(bus.aref_busy),    32'd1);
    #2;
    sys_rst_n = 1'b0;
    init_end  = 1'b0;
    #1;
    check("t5_cmd",  32'(bus.aref_cmd_out), 32'(NOP));
    check("t5_debt", 32'(bus.aref_debt),    32'd0);
    check("t5_busy", 32'(bus.aref_busy),    32'd0);
    check("t5_req",  32'(bus.aref_req),     32'd0);
    check("t5_end",  32'(bus.aref_end),     32'd0);
`ifdef AREF_STATS_EN
    check("t5_total", 32'(bus.aref_total),    32'd0);
    check("t5_ovf",   32'(bus.aref_overflow), 32'd0);
`endif

    // Engine inert while init_end is low
    @(posedge sys_clk);
    #1;
    sys_rst_n = 1'b1;
    ecnt      = 0;
    for (int e = 1; e <= 5000; e++) begin
      step_to(e);
      check("t6_req", 32'(bus.aref_req),     32'd0);
      check("t6_cmd", 32'(bus.aref_cmd_out), 32'(NOP));
    end
    init_end = 1'b1;
    ecnt     = 0;
    step_to(1549);
    check("t6_req_early", 32'(bus.aref_req), 32'd0);
    step_to(1550);
    check("t6_req_tick",  32'(bus.aref_req),  32'd1);
    check("t6_debt_tick", 32'(bus.aref_debt), 32'd1);
    bus.aref_en = 1'b0;

    // Two AUTO REFRESH commands per service
    init_end2    = 1'b1;
    bus2.aref_en = 1'b1;
    ecnt         = 0;
    step_to(19);
    check("t2_debt0", 32'(bus2.aref_debt), 32'd0);
    step_to(20);
    check("t2_debt1", 32'(bus2.aref_debt), 32'd1);
    for (int e = 21; e <= 41; e++) begin
      step_to(e);
      exp_cmd = (e == 22) ? PRE : (e == 25 || e == 33) ? AREF : NOP;
      check("t2_cmd", 32'(bus2.aref_cmd_out), 32'(exp_cmd));
      check("t2_end", 32'(bus2.aref_end),     32'(e == 40));
      if (e == 40) check("t2_debt_tick", 32'(bus2.aref_debt), 32'd2);
    end
    check("t2_debt_after", 32'(bus2.aref_debt), 32'd1);
    check("t2_idle",       32'(bus2.aref_busy), 32'd0);
`ifdef AREF_STATS_EN
    check("t2_total",      32'(bus2.aref_total), 32'd2);
`endif
    step_to(42);
    check("t2_rearm", 32'(bus2.aref_busy), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

`default_nettype wire
